fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, registers fetched words into
// IF/ID and redirects on branches resolved in decode. Parks a word acked during a stall.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        uncond_br,
  input  logic        br_reg,
  input  logic [63:0] br_reg_val,
  output logic [31:0] if_id_instr,
  output logic [63:0] if_id_pc,
  output logic        if_id_valid,
  output logic [10:0] opcode
);

  typedef enum logic [1:0] {StBoot, StWait, StHold} state_e;

  state_e      r_state, w_state_d;
  logic [63:0] r_pc, w_pc_d;
  logic [31:0] r_instr, w_instr_d;
  logic [63:0] r_ifpc, w_ifpc_d;
  logic        r_valid, w_valid_d;
  logic [31:0] r_buf, w_buf_d;

  logic        w_redirect;
  logic [63:0] w_off19;
  logic [63:0] w_off26;
  logic [63:0] w_target;
  logic [63:0] w_pc_inc;

  always_comb begin
    w_redirect = br_taken & ~stall;
    w_off19    = {{45{r_instr[23]}}, r_instr[23:5]};
    w_off26    = {{38{r_instr[25]}}, r_instr[25:0]};
    w_target   = br_reg ? br_reg_val
                        : r_ifpc + ((uncond_br ? w_off26 : w_off19) << 2);
    w_pc_inc   = r_pc + 64'd4;
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_ifpc_d  = r_ifpc;
    w_valid_d = r_valid;
    w_buf_d   = r_buf;
    if (w_redirect) begin
      // Redirect wins over everything, including an ack arriving this cycle.
      w_pc_d    = w_target;
      w_instr_d = 32'h0;
      w_valid_d = 1'b0;
      w_buf_d   = 32'h0;
      w_state_d = StWait;
    end else begin
      unique case (r_state)
        StBoot: begin
          w_instr_d = 32'h0;
          w_valid_d = 1'b0;
          w_state_d = StWait;
        end
        StWait: begin
          if (imem_ack && !stall) begin
            w_instr_d = imem_rdata;
            w_ifpc_d  = r_pc;
            w_valid_d = 1'b1;
            w_pc_d    = w_pc_inc;
          end else if (imem_ack) begin
            w_buf_d   = imem_rdata;
            w_state_d = StHold;
          end else if (!stall) begin
            w_instr_d = 32'h0;
            w_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            w_instr_d = r_buf;
            w_ifpc_d  = r_pc;
            w_valid_d = 1'b1;
            w_pc_d    = w_pc_inc;
            w_state_d = StWait;
          end
        end
        default: w_state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StBoot;
      r_pc    <= 64'h0;
      r_instr <= 32'h0;
      r_ifpc  <= 64'h0;
      r_valid <= 1'b0;
      r_buf   <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_ifpc  <= w_ifpc_d;
      r_valid <= w_valid_d;
      r_buf   <= w_buf_d;
    end
  end

  assign pc          = r_pc;
  assign imem_req    = (r_state == StWait);
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_ifpc;
  assign if_id_valid = r_valid;
  assign opcode      = r_instr[31:21];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed branch/stall/reset vectors, a rule-level model compared every
// cycle, plus literal expectations at key points.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic        uncond_br;
  logic        br_reg;
  logic [63:0] br_reg_val;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
  logic [10:0] opcode;

  logic        use_pc_data;
  logic [31:0] rdata_drv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = use_pc_data ? (pc[31:0] ^ 32'hA500_0000) : rdata_drv;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .uncond_br  (uncond_br),
    .br_reg     (br_reg),
    .br_reg_val (br_reg_val),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid),
    .opcode     (opcode)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: fresh = one idle cycle after reset; held = a word is parked waiting for stall to drop.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_buf;
  logic        m_valid, m_fresh, m_held;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 0; m_ifpc = 0; m_instr = 0; m_buf = 0;
      m_valid = 0; m_fresh = 1; m_held = 0;
    end else begin
      longint      off;
      logic [63:0] tgt;
      logic [25:0] i26;
      logic [18:0] i19;
      i26 = m_instr[25:0];
      i19 = m_instr[23:5];
      if (uncond_br) begin
        off = longint'(i26);
        if (i26[25]) off = off - (longint'(1) << 26);
      end else begin
        off = longint'(i19);
        if (i19[18]) off = off - (longint'(1) << 19);
      end
      tgt = br_reg ? br_reg_val : m_ifpc + 64'(off * 4);
      if (br_taken && !stall) begin
        m_pc = tgt; m_instr = 0; m_valid = 0;
        m_held = 0; m_buf = 0; m_fresh = 0;
      end else if (m_fresh) begin
        m_fresh = 0; m_instr = 0; m_valid = 0;
      end else if (m_held) begin
        if (!stall) begin
          m_instr = m_buf; m_ifpc = m_pc; m_valid = 1;
          m_pc = m_pc + 64'd4; m_held = 0;
        end
      end else if (imem_ack && !stall) begin
        m_instr = imem_rdata; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 64'd4;
      end else if (imem_ack) begin
        m_buf = imem_rdata; m_held = 1;
      end else if (!stall) begin
        m_instr = 0; m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_pc", pc, m_pc);
    chk("m_req", 64'(imem_req), 64'(!m_fresh && !m_held));
    chk("m_instr", 64'(if_id_instr), 64'(m_instr));
    chk("m_ifpc", if_id_pc, m_ifpc);
    chk("m_valid", 64'(if_id_valid), 64'(m_valid));
    chk("m_opcode", 64'(opcode), 64'(m_instr >> 21));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 0; imem_ack = 0; rdata_drv = 0; stall = 0; br_taken = 0;
    uncond_br = 0; br_reg = 0; br_reg_val = 0; use_pc_data = 0;
    #3;
    chk("rst_pc", pc, 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);
    chk("rst_instr", 64'(if_id_instr), 64'h0);
    chk("rst_valid", 64'(if_id_valid), 64'h0);
    step();
    reset = 1; use_pc_data = 1; imem_ack = 1;
    step();
    chk("boot_req", 64'(imem_req), 64'h1);
    chk("boot_valid", 64'(if_id_valid), 64'h0);
    step();
    chk("first_ifpc", if_id_pc, 64'h0);
    chk("first_instr", 64'(if_id_instr), 64'hA500_0000);
    chk("first_valid", 64'(if_id_valid), 64'h1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("stream_ifpc", if_id_pc, 64'(4 * i));
      chk("stream_valid", 64'(if_id_valid), 64'h1);
    end
    // Stall with ack: word parks, later acks ignored.
    use_pc_data = 0; rdata_drv = 32'hF840_03E1; stall = 1;
    step();
    chk("hold_pc", pc, 64'h10);
    chk("hold_ifpc", if_id_pc, 64'hC);
    chk("hold_req", 64'(imem_req), 64'h0);
    rdata_drv = 32'h1234_5678;
    step();
    step();
    stall = 0; imem_ack = 0;
    step();
    chk("unhold_instr", 64'(if_id_instr), 64'hF840_03E1);
    chk("unhold_ifpc", if_id_pc, 64'h10);
    chk("unhold_pc", pc, 64'h14);
    // BR to 0x100 with same-cycle ack dropped.
    br_taken = 1; br_reg = 1; br_reg_val = 64'h100; imem_ack = 1;
    step();
    chk("br_pc", pc, 64'h100);
    chk("br_valid", 64'(if_id_valid), 64'h0);
    br_taken = 0; br_reg = 0; rdata_drv = 32'h1400_0004;
    step();
    chk("b_instr", 64'(if_id_instr), 64'h1400_0004);
    br_taken = 1; uncond_br = 1; rdata_drv = 32'hDEAD_BEEF;
    step();
    chk("b_pc", pc, 64'h110);
    chk("b_valid", 64'(if_id_valid), 64'h0);
    br_taken = 0; imem_ack = 0;
    step();
    chk("b_lost", 64'(if_id_instr), 64'h0);
    // CBZ imm19 = -2 from 0x40.
    br_taken = 1; br_reg = 1; br_reg_val = 64'h40;
    step();
    br_taken = 0; br_reg = 0; imem_ack = 1; rdata_drv = 32'hB4FF_FFC0;
    step();
    chk("cbz_opcode", 64'(opcode), 64'h5A7);
    chk("cbz_ifpc", if_id_pc, 64'h40);
    imem_ack = 0; br_taken = 1; uncond_br = 0;
    step();
    chk("cbz_pc", pc, 64'h38);
    br_reg = 1; br_reg_val = 64'h2000;
    step();
    chk("brreg_pc", pc, 64'h2000);
    br_reg_val = 64'h3000; stall = 1;
    step();
    chk("stall_br_pc", pc, 64'h2000);
    stall = 0; br_taken = 0; br_reg = 0;
    // pc+4 wraps to zero.
    br_taken = 1; br_reg = 1; br_reg_val = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    br_taken = 0; br_reg = 0; imem_ack = 1; rdata_drv = 32'h1111_1111;
    step();
    chk("wrap_pc", pc, 64'h0);
    chk("wrap_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    // Reset while holding a buffered word.
    stall = 1; rdata_drv = 32'hCAFE_F00D;
    step();
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    chk("mid_rst_pc", pc, 64'h0);
    chk("mid_rst_req", 64'(imem_req), 64'h0);
    chk("mid_rst_ifpc", if_id_pc, 64'h0);
    chk("mid_rst_valid", 64'(if_id_valid), 64'h0);
    step();
    reset = 1; stall = 0; use_pc_data = 1;
    step();
    chk("rel_pc", pc, 64'h0);
    chk("rel_req", 64'(imem_req), 64'h1);
    step();
    chk("rel_instr", 64'(if_id_instr), 64'hA500_0000);
    chk("rel_ifpc", if_id_pc, 64'h0);
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
